// File: rtl/serdes_rx_pkg.sv
// Shared types and sizing for the serdes_1to10_rx receive deserializer.
package serdes_rx_pkg;

    localparam int unsigned DW_DEFAULT = 10;
    localparam int unsigned CNT_W      = $clog2(DW_DEFAULT);

    typedef logic [DW_DEFAULT-1:0] word_t;

endpackage

// File: rtl/serdes_bitslip_det.sv
// Bit-slip request detector: one-cycle slip on each falling edge of bitslip_ctrl_n.
// Present only when SERDES_BITSLIP_EN is defined.
`ifdef SERDES_BITSLIP_EN
module serdes_bitslip_det (
    input  logic clk,
    input  logic reset,
    input  logic bitslip_ctrl_n,
    output logic slip_c
);

    logic bs_q;

    // Resets to 0 so a low input right after reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bs_q <= 1'b0;
        end else begin
            bs_q <= bitslip_ctrl_n;
        end
    end

    assign slip_c = bs_q & ~bitslip_ctrl_n;

endmodule
`endif

// File: rtl/serdes_1to10_rx.sv
// 1:DW serial-to-parallel receive deserializer with bit-slip word alignment.
// Slip logic is built only when SERDES_BITSLIP_EN is defined.
module serdes_1to10_rx
    import serdes_rx_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clkGHz,
    input  logic          reset,
    input  logic          data_i,
    input  logic          enable_n,
    input  logic          bitslip_ctrl_n,
    output logic [DW-1:0] data_o,
    output logic          ready
);

    localparam int unsigned   CW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    logic slip_c;

`ifdef SERDES_BITSLIP_EN
    serdes_bitslip_det u_bitslip_det (
        .clk            (clkGHz),
        .reset          (reset),
        .bitslip_ctrl_n (bitslip_ctrl_n),
        .slip_c         (slip_c)
    );
`else
    logic unused_bitslip;
    assign unused_bitslip = bitslip_ctrl_n;
    assign slip_c         = 1'b0;
`endif

    logic [DW-1:0] sr;
    logic [DW-1:0] sr_d;
    logic [DW-1:0] data_d;
    logic [DW-1:0] shifted_c;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          ready_d;

    // New bit enters at the MSB so the first bit of a word ends up in bit 0.
    assign shifted_c = {data_i, sr[DW-1:1]};

    // Priority: disabled > slip > shift / word complete.
    always_comb begin
        sr_d    = sr;
        cnt_d   = cnt;
        data_d  = data_o;
        ready_d = 1'b0;
        if (!enable_n && !slip_c) begin
            sr_d = shifted_c;
            if (cnt == CNT_LAST) begin
                cnt_d   = '0;
                data_d  = shifted_c;
                ready_d = 1'b1;
            end else begin
                cnt_d = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clkGHz) begin
        if (reset) begin
            sr     <= '0;
            cnt    <= '0;
            data_o <= '0;
            ready  <= 1'b0;
        end else begin
            sr     <= sr_d;
            cnt    <= cnt_d;
            data_o <= data_d;
            ready  <= ready_d;
        end
    end

endmodule

// File: tb/tb_serdes_1to10_rx.sv
// Directed self-checking bench for serdes_1to10_rx; expectations follow SERDES_BITSLIP_EN.
module tb_serdes_1to10_rx;
    import serdes_rx_pkg::*;

    logic  clkGHz;
    logic  reset;
    logic  data_i;
    logic  enable_n;
    logic  bitslip_ctrl_n;
    word_t data_o;
    logic  ready;

    int n_cmp;
    int n_err;

    serdes_1to10_rx #(.DW(10)) dut (
        .clkGHz         (clkGHz),
        .reset          (reset),
        .data_i         (data_i),
        .enable_n       (enable_n),
        .bitslip_ctrl_n (bitslip_ctrl_n),
        .data_o         (data_o),
        .ready          (ready)
    );

    initial begin
        clkGHz = 1'b0;
        forever #5 clkGHz = ~clkGHz;
    end

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the next rising edge.
    task automatic cyc(input logic d, input logic en_n, input logic bs_n);
        data_i         = d;
        enable_n       = en_n;
        bitslip_ctrl_n = bs_n;
        @(posedge clkGHz);
        #1;
    endtask

    initial begin
        word_t pat;
        word_t exp_words [4];
        int    exp_end   [4];
        int    nw;

        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b1;
        data_i         = 1'b0;
        enable_n       = 1'b1;
        bitslip_ctrl_n = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("reset_data", data_o, 10'h000);
        chk("reset_ready", 10'(ready), 10'h000);
        reset = 1'b0;

        // Basic word 1,0,1,1,0,0,0,0,0,1 -> 10'h20D
        pat = 10'h20D;
        for (int i = 0; i < 10; i++) begin
            cyc(pat[i], 1'b0, 1'b1);
            if (i < 9) begin
                chk("basic_no_ready", 10'(ready), 10'h000);
            end else begin
                chk("basic_ready", 10'(ready), 10'h001);
                chk("basic_data", data_o, 10'h20D);
            end
        end
        cyc(1'b0, 1'b1, 1'b1);
        chk("basic_ready_one_cycle", 10'(ready), 10'h000);
        chk("basic_data_hold", data_o, 10'h20D);

        // Enable hold after the 4th bit; a slip pulse while disabled is dropped
        for (int i = 0; i < 4; i++) begin
            cyc(pat[i], 1'b0, 1'b1);
        end
        chk("hold_pre_no_ready", 10'(ready), 10'h000);
        for (int h = 0; h < 5; h++) begin
            cyc(1'($urandom_range(0, 1)), 1'b1, (h == 1) ? 1'b0 : 1'b1);
            chk("hold_ready", 10'(ready), 10'h000);
            chk("hold_data", data_o, 10'h20D);
        end
        for (int i = 4; i < 10; i++) begin
            cyc(pat[i], 1'b0, 1'b1);
            if (i < 9) begin
                chk("hold_no_ready", 10'(ready), 10'h000);
            end else begin
                chk("hold_resume_ready", 10'(ready), 10'h001);
                chk("hold_resume_data", data_o, 10'h20D);
            end
        end

        // Stream of 10'h001 words; slip drops stream bit 13 (a 0), control then held low 20 cycles.
        // Dropping a bit shifts later bits one position down, so the next 1 lands in bit 9.
`ifdef SERDES_BITSLIP_EN
        exp_words = '{10'h001, 10'h201, 10'h200, 10'h200};
        exp_end   = '{9, 20, 30, 40};
`else
        exp_words = '{10'h001, 10'h001, 10'h001, 10'h001};
        exp_end   = '{9, 19, 29, 39};
`endif
        nw = 0;
        for (int s = 0; s <= 40; s++) begin
            cyc((s % 10) == 0, 1'b0, (s >= 13 && s <= 32) ? 1'b0 : 1'b1);
            if (ready) begin
                if (nw < 4) begin
                    chk("slip_word_data", data_o, exp_words[nw]);
                    chk("slip_word_time", 10'(s), 10'(exp_end[nw]));
                end
                nw++;
            end
        end
        chk("slip_word_count", 10'(nw), 10'd4);

        // Realign with reset, then slip on the cnt = 9 cycle
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        chk("rst2_data", data_o, 10'h000);
        pat = 10'h153;
        for (int i = 0; i < 9; i++) begin
            cyc(pat[i], 1'b0, 1'b1);
        end
        chk("end_pre_no_ready", 10'(ready), 10'h000);
        cyc(1'b1, 1'b0, 1'b0);
`ifdef SERDES_BITSLIP_EN
        chk("end_slip_no_ready", 10'(ready), 10'h000);
        chk("end_slip_data", data_o, 10'h000);
        cyc(1'b0, 1'b0, 1'b1);
        chk("end_late_ready", 10'(ready), 10'h001);
        chk("end_late_data", data_o, 10'h153);
`else
        chk("end_noslip_ready", 10'(ready), 10'h001);
        chk("end_noslip_data", data_o, 10'h353);
        cyc(1'b0, 1'b0, 1'b1);
        chk("end_noslip_after", 10'(ready), 10'h000);
        chk("end_noslip_hold", data_o, 10'h353);
`endif

        // Reset after 6 bits discards the partial word
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
        end
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        chk("midrst_data", data_o, 10'h000);
        chk("midrst_ready", 10'(ready), 10'h000);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            if (i < 9) begin
                chk("midrst_no_ready", 10'(ready), 10'h000);
            end else begin
                chk("midrst_word_ready", 10'(ready), 10'h001);
                chk("midrst_word_data", data_o, 10'h3FF);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
